// File: rtl/secure_link_pkg.sv
// rtl/secure_link_pkg.sv - shared constants and types for the tagged frame link
package secure_link_pkg;

    localparam int FRAME_W   = 16;
    localparam int TAG_W     = 8;
    localparam int PAYLOAD_W = 8;

    localparam logic [TAG_W-1:0] BYPASS_TAG  = 8'hFF;
    localparam logic [7:0]       DEFAULT_KEY = 8'h5A;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        CHECK   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable down-counter with an expiry flag
module lockout_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // done marks the edge on which the count reaches zero, so the owner
    // leaves its timed state exactly load_val cycles after the load edge.
    assign done = en && !load && (count_q <= W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/secure_frame_receiver.sv
// rtl/secure_frame_receiver.sv - tag-chain authenticating frame receiver with lockout
module secure_frame_receiver
    import secure_link_pkg::*;
#(
    parameter logic [7:0] KEY         = DEFAULT_KEY,
    parameter int         MAX_ERR     = 4,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FRAME_W-1:0]   in_frame,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [7:0]           err_cnt,
    output logic                 alarm,
    output logic                 lock
);

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] prev_q, prev_d;
    logic [3:0]           cerr_q, cerr_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] out_data_q, out_data_d;
    logic                 alarm_q, alarm_d;
    logic                 timer_load;
    logic                 timer_done;
    logic                 accept;
    logic                 match;
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;

    assign tag      = in_frame[FRAME_W-1:PAYLOAD_W];
    assign payload  = in_frame[PAYLOAD_W-1:0];
    assign match    = (tag == (prev_q ^ KEY));
    assign in_ready = rst_n && (state_q != LOCKOUT) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    lockout_timer #(.W(8)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (8'(LOCK_CYCLES)),
        .en       (state_q == LOCKOUT),
        .done     (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cerr_d      = cerr_q;
        err_cnt_d   = err_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        alarm_d     = 1'b0;
        timer_load  = 1'b0;
        case (state_q)
            SYNC: begin
                if (accept) begin
                    prev_d  = payload;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept && match) begin
                    out_data_d  = payload;
                    out_valid_d = 1'b1;
                    prev_d      = payload;
                    cerr_d      = '0;
                end else if (accept) begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    alarm_d = (tag == BYPASS_TAG);
                    if (cerr_q + 4'd1 == 4'(MAX_ERR)) begin
                        state_d    = LOCKOUT;
                        timer_load = 1'b1;
                        cerr_d     = '0;
                    end else begin
                        cerr_d = cerr_q + 4'd1;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            prev_q      <= '0;
            cerr_q      <= '0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cerr_q      <= cerr_d;
            err_cnt_q   <= err_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            alarm_q     <= alarm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_cnt   = err_cnt_q;
    assign alarm     = alarm_q;
    assign lock      = (state_q == LOCKOUT);

endmodule

// File: tb/tb_secure_frame_receiver.sv
// tb/tb_secure_frame_receiver.sv - self-checking bench for secure_frame_receiver
module tb_secure_frame_receiver;

    localparam logic [7:0] KEY         = 8'h5A;
    localparam int         MAX_ERR     = 4;
    localparam int         LOCK_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_frame;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  err_cnt;
    logic        alarm;
    logic        lock;

    always #5 clk = ~clk;

    secure_frame_receiver #(
        .KEY         (KEY),
        .MAX_ERR     (MAX_ERR),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_frame  (in_frame),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_cnt   (err_cnt),
        .alarm     (alarm),
        .lock      (lock)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: link-level view of the receiver
    bit       m_synced;
    bit [7:0] m_prev;
    int       m_consec;
    int       m_err;
    int       m_lock_left;
    bit       m_ov;
    bit [7:0] m_data;
    bit       m_alarm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_prev = 0; m_consec = 0; m_err = 0;
        m_lock_left = 0; m_ov = 0; m_data = 0; m_alarm = 0;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] f, input bit r, input bit rs, input bit rdy);
        bit [7:0] tag;
        bit [7:0] pl;
        tag = f[15:8];
        pl  = f[7:0];
        if (!rs) begin
            model_reset();
            return;
        end
        m_alarm = 0;
        m_ov    = m_ov && !r;
        if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (v && rdy) begin
            if (!m_synced) begin
                m_prev   = pl;
                m_synced = 1;
            end else if (tag == (m_prev ^ KEY)) begin
                m_ov     = 1;
                m_data   = pl;
                m_prev   = pl;
                m_consec = 0;
            end else begin
                if (m_err < 255) m_err++;
                m_alarm = (tag == 8'hFF);
                m_consec++;
                if (m_consec == MAX_ERR) begin
                    m_consec    = 0;
                    m_lock_left = LOCK_CYCLES;
                    m_synced    = 0;
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [15:0] f, input bit r, input bit rs);
        bit exp_rdy;
        in_valid  = v;
        in_frame  = f;
        out_ready = r;
        rst_n     = rs;
        #1;
        exp_rdy = rs && (m_lock_left == 0) && (!m_ov || r);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge(v, f, r, rs, exp_rdy);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("alarm", 32'(alarm), 32'(m_alarm));
        chk("lock", 32'(lock), 32'(m_lock_left > 0));
    endtask

    typedef struct {
        bit          v;
        logic [15:0] f;
        bit          ov;
        logic [7:0]  data;
        logic [7:0]  err;
        bit          alarm;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int       lock_seen;
        int       guard;
        bit [7:0] tg;
        bit [7:0] pl;

        tbl[0] = '{1'b1, 16'h0011, 1'b0, 8'h00, 8'd0, 1'b0};
        tbl[1] = '{1'b1, 16'h4B22, 1'b1, 8'h22, 8'd0, 1'b0};
        tbl[2] = '{1'b1, 16'hFF33, 1'b0, 8'h22, 8'd1, 1'b1};
        tbl[3] = '{1'b1, 16'h7844, 1'b1, 8'h44, 8'd1, 1'b0};
        tbl[4] = '{1'b1, 16'h1EA5, 1'b1, 8'hA5, 8'd1, 1'b0};
        tbl[5] = '{1'b1, 16'hFF44, 1'b1, 8'h44, 8'd1, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 8'h44, 8'd1, 1'b0};

        model_reset();
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_lock", 32'(lock), 32'd0);

        // chain accept, bypass rejection, tag collision
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].f, 1, 1);
            chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_alarm", i), 32'(alarm), 32'(tbl[i].alarm));
        end

        // lockout after MAX_ERR consecutive mismatches
        for (int i = 0; i < MAX_ERR; i++) step(1, 16'h0000, 1, 1);
        chk("lockout_entry", 32'(lock), 32'd1);
        lock_seen = 1;
        guard     = 0;
        while (lock && guard < 100) begin
            step(1, 16'h0055, 1, 1);
            if (lock) lock_seen++;
            guard++;
        end
        chk("lockout_len", 32'(lock_seen), 32'(LOCK_CYCLES));
        step(1, 16'h0055, 1, 1);
        chk("resync_no_out", 32'(out_valid), 32'd0);
        chk("lockout_err", 32'(err_cnt), 32'd5);

        // backpressure then back-to-back
        step(1, 16'h0F66, 1, 1);
        chk("bp_first", 32'(out_data), 32'h66);
        step(1, 16'h3C77, 0, 1);
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        step(1, 16'h3C77, 0, 1);
        chk("bp_hold_data", 32'(out_data), 32'h66);
        step(1, 16'h3C77, 1, 1);
        chk("bp_resume", 32'(out_data), 32'h77);
        step(1, 16'h2D88, 1, 1);
        chk("bp_b2b_valid", 32'(out_valid), 32'd1);
        chk("bp_b2b_data", 32'(out_data), 32'h88);

        // reset in the middle of lockout
        for (int i = 0; i < MAX_ERR; i++) step(1, 16'h0000, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 16'h0000, 1, 1);
        step(0, 16'h0000, 1, 0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        step(1, 16'h0011, 1, 1);
        chk("rst_sync_no_out", 32'(out_valid), 32'd0);
        step(1, 16'h4B22, 1, 1);
        chk("rst_chain", 32'(out_data), 32'h22);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pl = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    tg = 8'hFF;
                2, 3, 4: tg = 8'($urandom);
                default: tg = m_prev ^ KEY;
            endcase
            step($urandom_range(0, 3) != 0, {tg, pl}, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 499) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
